updn_mod_counter: RTL and testbench

Parametrised modulo-N up/down counter, the successor to the fixed 4-bit free-running down counter. Adds width and modulus parameters, direction control, count enable, parallel load, selectable wrap or saturate mode, and terminal-count and wrap status outputs. Used as a general timing and sequence counter in the sequential-counter library.

---
 rtl/updn_mod_counter_if.sv | 16 +
 rtl/updn_mod_counter.sv | 59 +++++
 tb/tb_updn_mod_counter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/updn_mod_counter_if.sv
// updn_mod_counter_if: control and status bundle for the up/down modulo counter
interface updn_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (output en, up_dn, load, load_val, input count, tc, wrap, ovf);
    modport slave  (input en, up_dn, load, load_val, output count, tc, wrap, ovf);
endinterface

// File: rtl/updn_mod_counter.sv
// updn_mod_counter: modulo-(MAX_VAL+1) up/down counter with load, wrap/saturate and status flags
module updn_mod_counter #(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 15,
    parameter int unsigned RST_VAL  = 15,
    parameter bit          SATURATE = 1'b0
) (
    input logic clk,
    input logic rst,
    updn_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             hit;

    // boundary is compared before stepping, so no intermediate value ever exceeds MAX
    assign hit      = bus.up_dn ? (count_q == MAX) : (count_q == '0);
    assign bus.tc   = bus.en & ~bus.load & ~rst & hit;
    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;

    // next state: load beats enable; at the boundary either wrap or hold and flag
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (bus.load) begin
            count_d = (bus.load_val > MAX) ? MAX : bus.load_val;
            ovf_d   = 1'b0;
        end else if (bus.en) begin
            if (!hit) begin
                count_d = bus.up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else if (SATURATE) begin
                ovf_d = 1'b1;
            end else begin
                count_d = bus.up_dn ? '0 : MAX;
                wrap_d  = 1'b1;
            end
        end
    end

    // state registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_updn_mod_counter.sv
// tb_updn_mod_counter: directed table-driven bench over four counter configurations
module tb_updn_mod_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_v [4];
    int   checks = 0;
    int   errors = 0;

    updn_mod_counter_if #(.WIDTH(4)) b0 ();
    updn_mod_counter_if #(.WIDTH(4)) b1 ();
    updn_mod_counter_if #(.WIDTH(4)) b2 ();
    updn_mod_counter_if #(.WIDTH(4)) b3 ();

    updn_mod_counter #(.WIDTH(4), .MAX_VAL(15), .RST_VAL(15), .SATURATE(1'b0)) u0 (.clk(clk), .rst(rst_v[0]), .bus(b0));
    updn_mod_counter #(.WIDTH(4), .MAX_VAL(9),  .RST_VAL(0),  .SATURATE(1'b0)) u1 (.clk(clk), .rst(rst_v[1]), .bus(b1));
    updn_mod_counter #(.WIDTH(4), .MAX_VAL(12), .RST_VAL(10), .SATURATE(1'b1)) u2 (.clk(clk), .rst(rst_v[2]), .bus(b2));
    updn_mod_counter #(.WIDTH(4), .MAX_VAL(12), .RST_VAL(7),  .SATURATE(1'b0)) u3 (.clk(clk), .rst(rst_v[3]), .bus(b3));

    typedef struct {
        int         d;
        logic       r, e, u, l;
        logic [3:0] lv;
        logic       t;
        logic [3:0] c;
        logic       w, o;
    } vec_t;

    vec_t v[$];

    function automatic void add(int d, logic r, logic e, logic u, logic l, logic [3:0] lv,
                                logic t, logic [3:0] c, logic w, logic o);
        vec_t x;
        x.d = d; x.r = r; x.e = e; x.u = u; x.l = l; x.lv = lv;
        x.t = t; x.c = c; x.w = w; x.o = o;
        v.push_back(x);
    endfunction

    task automatic drive(input int d, input logic r, input logic e, input logic u, input logic l, input logic [3:0] lv);
        rst_v = '{1'b0, 1'b0, 1'b0, 1'b0};
        b0.en = 0; b0.load = 0; b1.en = 0; b1.load = 0;
        b2.en = 0; b2.load = 0; b3.en = 0; b3.load = 0;
        rst_v[d] = r;
        case (d)
            0: begin b0.en = e; b0.up_dn = u; b0.load = l; b0.load_val = lv; end
            1: begin b1.en = e; b1.up_dn = u; b1.load = l; b1.load_val = lv; end
            2: begin b2.en = e; b2.up_dn = u; b2.load = l; b2.load_val = lv; end
            default: begin b3.en = e; b3.up_dn = u; b3.load = l; b3.load_val = lv; end
        endcase
    endtask

    task automatic sample(input int d, output logic [3:0] c, output logic t, output logic w, output logic o);
        case (d)
            0: begin c = b0.count; t = b0.tc; w = b0.wrap; o = b0.ovf; end
            1: begin c = b1.count; t = b1.tc; w = b1.wrap; o = b1.ovf; end
            2: begin c = b2.count; t = b2.tc; w = b2.wrap; o = b2.ovf; end
            default: begin c = b3.count; t = b3.tc; w = b3.wrap; o = b3.ovf; end
        endcase
    endtask

    task automatic chk(input string n, input int idx, input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", n, idx, a, e);
        end
    endtask

    initial begin
        logic [3:0] c;
        logic       t, w, o;
        logic [3:0] rv [4];
        rv = '{4'd15, 4'd0, 4'd10, 4'd7};

        // Test 1 down count with one wrap 0->15
        for (int i = 1; i <= 17; i++) begin
            int pre;
            pre = (i <= 16) ? 16 - i : 15;
            add(0, 0, 1, 0, 0, 0, pre == 0, (pre == 0) ? 4'd15 : 4'(pre - 1), pre == 0, 0);
        end
        // Test 5 direction flip and enable gating from 5
        add(0, 0, 0, 0, 1, 5, 0, 5, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 6, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 7, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 6, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 5, 0, 0);
        // Test 6 reset on the wrapping edge
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 15, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 15, 0, 0);
        // Test 2 up count modulo 10
        for (int i = 1; i <= 12; i++) begin
            int pre;
            pre = (i <= 10) ? i - 1 : i - 11;
            add(1, 0, 1, 1, 0, 0, pre == 9, (pre == 9) ? 4'd0 : 4'(pre + 1), pre == 9, 0);
        end
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1, 9, 1, 0);
        add(1, 0, 1, 1, 1, 13, 0, 9, 0, 0);
        // Test 3 saturation
        add(2, 0, 1, 1, 0, 0, 0, 11, 0, 0);
        add(2, 0, 1, 1, 0, 0, 0, 12, 0, 0);
        add(2, 0, 1, 1, 0, 0, 1, 12, 0, 1);
        add(2, 0, 1, 1, 0, 0, 1, 12, 0, 1);
        add(2, 0, 1, 1, 0, 0, 1, 12, 0, 1);
        add(2, 0, 1, 1, 1, 3, 0, 3, 0, 0);
        add(2, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        add(2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Test 4 load priority, clamp and reset override
        add(3, 0, 1, 1, 1, 14, 0, 12, 0, 0);
        add(3, 0, 1, 0, 1, 15, 0, 12, 0, 0);
        add(3, 0, 1, 1, 1, 12, 0, 12, 0, 0);
        add(3, 1, 1, 1, 1, 3, 0, 7, 0, 0);
        add(3, 0, 0, 0, 1, 12, 0, 12, 0, 0);
        add(3, 0, 1, 1, 0, 0, 1, 0, 1, 0);
        add(3, 0, 1, 1, 0, 0, 0, 1, 0, 0);

        rst_v = '{1'b1, 1'b1, 1'b1, 1'b1};
        b0.en = 0; b0.load = 0; b0.up_dn = 0; b0.load_val = 0;
        b1.en = 0; b1.load = 0; b1.up_dn = 0; b1.load_val = 0;
        b2.en = 0; b2.load = 0; b2.up_dn = 0; b2.load_val = 0;
        b3.en = 0; b3.load = 0; b3.up_dn = 0; b3.load_val = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            sample(d, c, t, w, o);
            chk("reset_count", d, c, rv[d]);
            chk("reset_wrap", d, {3'b0, w}, 4'd0);
            chk("reset_ovf", d, {3'b0, o}, 4'd0);
        end

        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            drive(v[i].d, v[i].r, v[i].e, v[i].u, v[i].l, v[i].lv);
            #1;
            sample(v[i].d, c, t, w, o);
            chk("tc", i, {3'b0, t}, {3'b0, v[i].t});
            @(posedge clk);
            #1;
            sample(v[i].d, c, t, w, o);
            chk("count", i, c, v[i].c);
            chk("wrap", i, {3'b0, w}, {3'b0, v[i].w});
            chk("ovf", i, {3'b0, o}, {3'b0, v[i].o});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
